// File: rtl/axi_req_tracker_pkg.sv
// Shared state encodings, AXI IDs and the registered flag decode for the
// SRAM-to-AXI request tracker.
package axi_req_tracker_pkg;

  localparam int unsigned IBURST_MAX_DEF = 4;
  localparam logic [3:0]  ID_INST_DEF    = 4'd0;
  localparam logic [3:0]  ID_DATA_DEF    = 4'd1;

  typedef enum logic [2:0] {
    D_IDLE, D_RADDR, D_RDATA, D_RDONE, D_WADDR, D_WDATA, D_WRESP, D_WDONE
  } dstate_e;

  typedef enum logic [1:0] {
    I_IDLE, I_LOCK, I_WAIT
  } istate_e;

  typedef struct packed {
    logic memory_access;
    logic raddr_ok;
    logic rdata_ok;
    logic waddr_ok;
    logic wdata_ok;
    logic write_ok;
  } dflags_t;

  function automatic dflags_t dflags_of(dstate_e s);
    dflags_t f;
    f.memory_access = (s != D_IDLE);
    f.raddr_ok      = (s == D_RDATA) || (s == D_RDONE);
    f.rdata_ok      = (s == D_RDONE);
    f.waddr_ok      = (s == D_WDATA) || (s == D_WRESP) || (s == D_WDONE);
    f.wdata_ok      = (s == D_WRESP) || (s == D_WDONE);
    f.write_ok      = (s == D_WDONE);
    return f;
  endfunction

endpackage

// File: rtl/axi_req_tracker_inst_rd.sv
// Instruction-side read tracker: holds the port lock across an IF refill
// burst and flags bursts that run past IBURST_MAX beats.
module axi_inst_rd_tracker
  import axi_req_tracker_pkg::*;
#(
  parameter int unsigned IBURST_MAX = IBURST_MAX_DEF,
  parameter logic [3:0]  ID_INST    = ID_INST_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inst_sram_req,
  input  logic       data_sram_req,
  input  logic       data_idle,
  input  logic       ar_hs,
  input  logic [3:0] arid,
  input  logic       r_hs,
  input  logic [3:0] rid,
  input  logic       rlast,
  output logic       inst_raddr_ok,
  output logic       inst_sram_using,
  output logic       burst_err
);

  localparam int unsigned      CNT_W   = $clog2(IBURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IBURST_MAX);

  istate_e          istate_q, istate_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             burst_err_q, burst_err_d;
  logic             using_q, raddr_ok_q;
  logic             ar_inst, r_inst;

  assign ar_inst = ar_hs && (arid == ID_INST);
  assign r_inst  = r_hs && (rid == ID_INST);

  always_comb begin
    istate_d   = istate_q;
    beat_cnt_d = beat_cnt_q;
    case (istate_q)
      // An inst AR seen without a prior lock still means a burst is in flight.
      I_IDLE: begin
        if (ar_inst)
          istate_d = I_WAIT;
        else if (inst_sram_req && data_idle && !data_sram_req)
          istate_d = I_LOCK;
      end
      I_LOCK: if (ar_inst) istate_d = I_WAIT;
      I_WAIT: begin
        if (r_inst) begin
          if (rlast) begin
            istate_d   = I_IDLE;
            beat_cnt_d = '0;
          end else if (beat_cnt_q != CNT_MAX) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      default: istate_d = I_IDLE;
    endcase
    burst_err_d = burst_err_q || (beat_cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      istate_q    <= I_IDLE;
      beat_cnt_q  <= '0;
      burst_err_q <= 1'b0;
      using_q     <= 1'b0;
      raddr_ok_q  <= 1'b0;
    end else begin
      istate_q    <= istate_d;
      beat_cnt_q  <= beat_cnt_d;
      burst_err_q <= burst_err_d;
      using_q     <= (istate_d != I_IDLE);
      raddr_ok_q  <= (istate_d == I_WAIT);
    end
  end

  assign inst_raddr_ok   = raddr_ok_q;
  assign inst_sram_using = using_q;
  assign burst_err       = burst_err_q;

endmodule

// File: rtl/axi_req_tracker.sv
// Handshake-state tracker feeding the SRAM-to-AXI bridge: data-side FSM here,
// instruction-side burst tracking in axi_inst_rd_tracker.
module axi_req_tracker
  import axi_req_tracker_pkg::*;
#(
  parameter int unsigned IBURST_MAX = IBURST_MAX_DEF,
  parameter logic [3:0]  ID_INST    = ID_INST_DEF,
  parameter logic [3:0]  ID_DATA    = ID_DATA_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inst_sram_req,
  input  logic       data_sram_req,
  input  logic       data_sram_wr,
  input  logic       arvalid,
  input  logic       arready,
  input  logic [3:0] arid,
  input  logic       rvalid,
  input  logic       rready,
  input  logic [3:0] rid,
  input  logic       rlast,
  input  logic       awvalid,
  input  logic       awready,
  input  logic       wvalid,
  input  logic       wready,
  input  logic       bvalid,
  input  logic       bready,
  output logic       memory_access,
  output logic       data_raddr_ok,
  output logic       data_rdata_ok,
  output logic       data_waddr_ok,
  output logic       data_wdata_ok,
  output logic       data_write_ok,
  output logic       inst_raddr_ok,
  output logic       inst_sram_using,
  output logic       burst_err
);

  dstate_e dstate_q, dstate_d;
  dflags_t dflags_q;
  logic    ar_hs, r_hs, aw_hs, w_hs, b_hs, data_idle;

  assign ar_hs     = arvalid && arready;
  assign r_hs      = rvalid && rready;
  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  assign b_hs      = bvalid && bready;
  assign data_idle = (dstate_q == D_IDLE);

  // Data wins a simultaneous start because the inst lock needs ~data_sram_req.
  always_comb begin
    dstate_d = dstate_q;
    case (dstate_q)
      D_IDLE:  if (data_sram_req && !inst_sram_using)
                 dstate_d = data_sram_wr ? D_WADDR : D_RADDR;
      D_RADDR: if (ar_hs && (arid == ID_DATA)) dstate_d = D_RDATA;
      D_RDATA: if (r_hs && (rid == ID_DATA))   dstate_d = D_RDONE;
      D_RDONE: dstate_d = D_IDLE;
      D_WADDR: if (aw_hs) dstate_d = D_WDATA;
      D_WDATA: if (w_hs)  dstate_d = D_WRESP;
      D_WRESP: if (b_hs)  dstate_d = D_WDONE;
      D_WDONE: dstate_d = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dstate_q <= D_IDLE;
      dflags_q <= '0;
    end else begin
      dstate_q <= dstate_d;
      dflags_q <= dflags_of(dstate_d);
    end
  end

  assign memory_access = dflags_q.memory_access;
  assign data_raddr_ok = dflags_q.raddr_ok;
  assign data_rdata_ok = dflags_q.rdata_ok;
  assign data_waddr_ok = dflags_q.waddr_ok;
  assign data_wdata_ok = dflags_q.wdata_ok;
  assign data_write_ok = dflags_q.write_ok;

  axi_inst_rd_tracker #(
    .IBURST_MAX (IBURST_MAX),
    .ID_INST    (ID_INST)
  ) u_inst_rd (
    .clk             (clk),
    .reset           (reset),
    .inst_sram_req   (inst_sram_req),
    .data_sram_req   (data_sram_req),
    .data_idle       (data_idle),
    .ar_hs           (ar_hs),
    .arid            (arid),
    .r_hs            (r_hs),
    .rid             (rid),
    .rlast           (rlast),
    .inst_raddr_ok   (inst_raddr_ok),
    .inst_sram_using (inst_sram_using),
    .burst_err       (burst_err)
  );

endmodule

// File: tb/tb_axi_req_tracker.sv
// Scenario bench for axi_req_tracker: per-cycle stimulus with the expected
// registered flags queued alongside and compared after each clock edge.
module tb_axi_req_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic       inst_sram_req, data_sram_req, data_sram_wr;
  logic       arvalid, arready, rvalid, rready, rlast;
  logic [3:0] arid, rid;
  logic       awvalid, awready, wvalid, wready, bvalid, bready;
  logic       memory_access, data_raddr_ok, data_rdata_ok, data_waddr_ok;
  logic       data_wdata_ok, data_write_ok, inst_raddr_ok, inst_sram_using, burst_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_req_tracker dut (
    .clk             (clk),
    .reset           (reset),
    .inst_sram_req   (inst_sram_req),
    .data_sram_req   (data_sram_req),
    .data_sram_wr    (data_sram_wr),
    .arvalid         (arvalid),
    .arready         (arready),
    .arid            (arid),
    .rvalid          (rvalid),
    .rready          (rready),
    .rid             (rid),
    .rlast           (rlast),
    .awvalid         (awvalid),
    .awready         (awready),
    .wvalid          (wvalid),
    .wready          (wready),
    .bvalid          (bvalid),
    .bready          (bready),
    .memory_access   (memory_access),
    .data_raddr_ok   (data_raddr_ok),
    .data_rdata_ok   (data_rdata_ok),
    .data_waddr_ok   (data_waddr_ok),
    .data_wdata_ok   (data_wdata_ok),
    .data_write_ok   (data_write_ok),
    .inst_raddr_ok   (inst_raddr_ok),
    .inst_sram_using (inst_sram_using),
    .burst_err       (burst_err)
  );

  typedef struct packed {
    logic       inst_req;
    logic       data_req;
    logic       wr;
    logic       ar;
    logic [3:0] arid;
    logic       r;
    logic [3:0] rid;
    logic       rlast;
    logic       aw;
    logic       w;
    logic       b;
  } stim_t;

  // Expected flag vector bit order: ma | raddr rdata | waddr wdata write | iraddr iusing | berr
  typedef struct packed {
    stim_t      s;
    logic [8:0] e;
  } step_t;

  step_t      plan_q[$];
  logic [8:0] exp_q[$];

  localparam logic [3:0] IDI = 4'd0;
  localparam logic [3:0] IDD = 4'd1;
  localparam stim_t      NOP = '0;

  function automatic stim_t s_req(logic i, logic d, logic w);
    stim_t s = '0;
    s.inst_req = i; s.data_req = d; s.wr = w;
    return s;
  endfunction
  function automatic stim_t s_ar(logic [3:0] id);
    stim_t s = '0;
    s.ar = 1'b1; s.arid = id;
    return s;
  endfunction
  function automatic stim_t s_r(logic [3:0] id, logic last);
    stim_t s = '0;
    s.r = 1'b1; s.rid = id; s.rlast = last;
    return s;
  endfunction
  function automatic stim_t s_aw();
    stim_t s = '0;
    s.aw = 1'b1;
    return s;
  endfunction
  function automatic stim_t s_w();
    stim_t s = '0;
    s.w = 1'b1;
    return s;
  endfunction
  function automatic stim_t s_b();
    stim_t s = '0;
    s.b = 1'b1;
    return s;
  endfunction

  function automatic logic [8:0] outs();
    return {memory_access, data_raddr_ok, data_rdata_ok, data_waddr_ok, data_wdata_ok,
            data_write_ok, inst_raddr_ok, inst_sram_using, burst_err};
  endfunction

  task automatic drive(input stim_t s);
    inst_sram_req = s.inst_req; data_sram_req = s.data_req; data_sram_wr = s.wr;
    arvalid = s.ar; arready = s.ar; arid = s.arid;
    rvalid = s.r; rready = s.r; rid = s.rid; rlast = s.rlast;
    awvalid = s.aw; awready = s.aw; wvalid = s.w; wready = s.w; bvalid = s.b; bready = s.b;
  endtask

  task automatic plan(input stim_t s, input logic [8:0] e);
    plan_q.push_back('{s: s, e: e});
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(NOP);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (outs() !== 9'b0) begin
      failures++; $display("FAIL reset_idle got=%b exp=%b", outs(), 9'b0);
    end
    drive(s_req(1'b1, 1'b1, 1'b0) | s_ar(IDI));
    @(posedge clk); #1;
    checks++;
    if (outs() !== 9'b0) begin
      failures++; $display("FAIL reset_held_with_req got=%b exp=%b", outs(), 9'b0);
    end
    drive(NOP);
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (outs() !== 9'b0) begin
      failures++; $display("FAIL reset_release got=%b exp=%b", outs(), 9'b0);
    end
  endtask

  task automatic test_data_read();
    int n = 0;
    step_t p;
    logic [8:0] e;
    plan(s_req(1'b0, 1'b1, 1'b0), 9'b1_00_000_00_0);
    plan(s_ar(IDD),               9'b1_10_000_00_0);
    plan(s_r(IDI, 1'b0),          9'b1_10_000_00_0);
    plan(NOP,                     9'b1_10_000_00_0);
    plan(s_r(IDD, 1'b1),          9'b1_11_000_00_0);
    plan(NOP,                     9'b0_00_000_00_0);
    while (plan_q.size() > 0) begin
      p = plan_q.pop_front();
      drive(p.s); exp_q.push_back(p.e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (outs() !== e) begin
        failures++; $display("FAIL data_read step %0d got=%b exp=%b", n, outs(), e);
      end
      n++;
    end
  endtask

  task automatic test_data_write();
    int n = 0;
    step_t p;
    logic [8:0] e;
    plan(s_req(1'b0, 1'b1, 1'b1), 9'b1_00_000_00_0);
    plan(s_aw(),                  9'b1_00_100_00_0);
    plan(NOP,                     9'b1_00_100_00_0);
    plan(s_w(),                   9'b1_00_110_00_0);
    plan(NOP,                     9'b1_00_110_00_0);
    plan(s_b(),                   9'b1_00_111_00_0);
    plan(NOP,                     9'b0_00_000_00_0);
    while (plan_q.size() > 0) begin
      p = plan_q.pop_front();
      drive(p.s); exp_q.push_back(p.e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (outs() !== e) begin
        failures++; $display("FAIL data_write step %0d got=%b exp=%b", n, outs(), e);
      end
      n++;
    end
  endtask

  task automatic test_inst_burst();
    int n = 0;
    step_t p;
    logic [8:0] e;
    plan(s_req(1'b1, 1'b0, 1'b0),                    9'b0_00_000_01_0);
    plan(s_ar(IDI),                                  9'b0_00_000_11_0);
    plan(s_r(IDI, 1'b0),                             9'b0_00_000_11_0);
    plan(s_req(1'b0, 1'b1, 1'b0) | s_r(IDI, 1'b0),   9'b0_00_000_11_0);
    plan(s_r(IDI, 1'b0),                             9'b0_00_000_11_0);
    plan(s_r(IDI, 1'b1),                             9'b0_00_000_00_0);
    plan(NOP,                                        9'b0_00_000_00_0);
    while (plan_q.size() > 0) begin
      p = plan_q.pop_front();
      drive(p.s); exp_q.push_back(p.e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (outs() !== e) begin
        failures++; $display("FAIL inst_burst step %0d got=%b exp=%b", n, outs(), e);
      end
      n++;
    end
  endtask

  task automatic test_contention();
    int n = 0;
    step_t p;
    logic [8:0] e;
    plan(s_req(1'b1, 1'b1, 1'b0),                    9'b1_00_000_00_0);
    plan(s_req(1'b1, 1'b0, 1'b0) | s_ar(IDD),        9'b1_10_000_00_0);
    plan(s_req(1'b1, 1'b0, 1'b0) | s_r(IDD, 1'b1),   9'b1_11_000_00_0);
    plan(s_req(1'b1, 1'b0, 1'b0),                    9'b0_00_000_00_0);
    plan(s_req(1'b1, 1'b0, 1'b0),                    9'b0_00_000_01_0);
    plan(s_ar(IDI),                                  9'b0_00_000_11_0);
    plan(s_r(IDI, 1'b1),                             9'b0_00_000_00_0);
    while (plan_q.size() > 0) begin
      p = plan_q.pop_front();
      drive(p.s); exp_q.push_back(p.e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (outs() !== e) begin
        failures++; $display("FAIL contention step %0d got=%b exp=%b", n, outs(), e);
      end
      n++;
    end
  endtask

  task automatic test_overrun();
    int n = 0;
    step_t p;
    logic [8:0] e;
    plan(s_ar(IDI),       9'b0_00_000_11_0);
    plan(s_r(IDI, 1'b0),  9'b0_00_000_11_0);
    plan(s_r(IDI, 1'b0),  9'b0_00_000_11_0);
    plan(s_r(IDI, 1'b0),  9'b0_00_000_11_0);
    plan(s_r(IDI, 1'b0),  9'b0_00_000_11_1);
    plan(s_r(IDI, 1'b0),  9'b0_00_000_11_1);
    plan(s_r(IDD, 1'b1),  9'b0_00_000_11_1);
    plan(s_r(IDI, 1'b1),  9'b0_00_000_00_1);
    plan(NOP,             9'b0_00_000_00_1);
    while (plan_q.size() > 0) begin
      p = plan_q.pop_front();
      drive(p.s); exp_q.push_back(p.e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (outs() !== e) begin
        failures++; $display("FAIL overrun step %0d got=%b exp=%b", n, outs(), e);
      end
      n++;
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    step_t p;
    logic [8:0] e;
    plan(s_req(1'b0, 1'b1, 1'b1), 9'b1_00_000_00_1);
    plan(s_aw(),                  9'b1_00_100_00_1);
    plan(s_w(),                   9'b1_00_110_00_1);
    plan(s_ar(IDI),               9'b1_00_110_11_1);
    plan(s_r(IDI, 1'b0),          9'b1_00_110_11_1);
    while (plan_q.size() > 0) begin
      p = plan_q.pop_front();
      drive(p.s); exp_q.push_back(p.e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (outs() !== e) begin
        failures++; $display("FAIL reset_mid_setup step %0d got=%b exp=%b", n, outs(), e);
      end
      n++;
    end
    drive(NOP);
    reset = 1'b1;
    #1;
    checks++;
    if (outs() !== 9'b0) begin
      failures++; $display("FAIL reset_mid_async got=%b exp=%b", outs(), 9'b0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    n = 0;
    plan(s_req(1'b0, 1'b1, 1'b0), 9'b1_00_000_00_0);
    plan(s_ar(IDD),               9'b1_10_000_00_0);
    plan(s_r(IDD, 1'b0),          9'b1_11_000_00_0);
    plan(NOP,                     9'b0_00_000_00_0);
    plan(s_req(1'b1, 1'b0, 1'b0), 9'b0_00_000_01_0);
    plan(s_ar(IDI),               9'b0_00_000_11_0);
    plan(s_r(IDI, 1'b1),          9'b0_00_000_00_0);
    while (plan_q.size() > 0) begin
      p = plan_q.pop_front();
      drive(p.s); exp_q.push_back(p.e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (outs() !== e) begin
        failures++; $display("FAIL reset_mid_resume step %0d got=%b exp=%b", n, outs(), e);
      end
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_data_read();
    test_data_write();
    test_inst_burst();
    test_contention();
    test_overrun();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
